conv_window_ctrl: RTL and testbench

//  Sequencer for the row-buffer line chain feeding a KxK convolution window.
//  - Accepts a raster pixel stream (valid/ready) and drives the shared shift enable of the line chain.
//  - Tracks row/column position in the frame.
//  - Flags each cycle on which the KxK window is fully populated and does not straddle a row wrap.
//  - Sits between the pixel source and the conv MAC array; one instance per conv layer.

---
 rtl/conv_pkg.sv | 11 +
 rtl/wrap_counter.sv | 28 ++
 rtl/conv_window_ctrl.sv | 147 ++++++++++++++
 tb/tb_conv_window_ctrl.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared types and width helpers for the convolution window sequencer.
package conv_pkg;

   typedef enum logic [1:0] {IDLE, FILL, RUN, DONE} conv_state_e;

   // Bit width able to index 0..n-1; never narrower than one bit.
   function automatic int cw(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/wrap_counter.sv
// Modulo counter 0..MAX with synchronous clear; wrap flags the terminal count.
module wrap_counter
   import conv_pkg::*;
#(
   parameter int MAX = 31,
   parameter int W   = cw(MAX + 1)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic         clr,
   output logic [W-1:0] count,
   output logic         wrap
);

   assign wrap = (count == W'(MAX));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (en) begin
         count <= wrap ? '0 : count + W'(1);
      end
   end

endmodule

// File: rtl/conv_window_ctrl.sv
// Sequencer for the line chain feeding a KxK convolution window.
// Optional window counter port enabled by CONV_WIN_PERF_CNT_EN.
// Handshakes: a transfer happens on a cycle where valid and ready are both high;
// valid never waits on ready and the payload holds while valid & ~ready.
module conv_window_ctrl
   import conv_pkg::*;
#(
   parameter int IMG_COLS = 32,
   parameter int IMG_ROWS = 32,
   parameter int KERNEL   = 5
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              start,
   input  logic                              in_valid,
   output logic                              in_ready,
   output logic                              buf_en,
   output logic                              win_valid,
   input  logic                              win_ready,
   output logic [cw(IMG_ROWS)-1:0]           win_row,
   output logic [cw(IMG_COLS)-1:0]           win_col,
   output logic                              busy,
   output logic                              frame_done,
`ifdef CONV_WIN_PERF_CNT_EN
   output logic [cw(IMG_ROWS*IMG_COLS+1)-1:0] win_count,
`endif
   output conv_state_e                       state_dbg
);

   localparam int COL_W = cw(IMG_COLS);
   localparam int ROW_W = cw(IMG_ROWS);

   conv_state_e      state_q, state_d;
   logic [COL_W-1:0] col_cnt;
   logic [ROW_W-1:0] row_cnt;
   logic             col_wrap, row_wrap;
   logic             in_done_q;
   logic             start_acc, accept, qualify, last_win;

   wrap_counter #(.MAX(IMG_COLS - 1), .W(COL_W)) u_col (
      .clk   (clk),
      .rst   (rst),
      .en    (accept),
      .clr   (start_acc),
      .count (col_cnt),
      .wrap  (col_wrap)
   );

   wrap_counter #(.MAX(IMG_ROWS - 1), .W(ROW_W)) u_row (
      .clk   (clk),
      .rst   (rst),
      .en    (accept & col_wrap),
      .clr   (start_acc),
      .count (row_cnt),
      .wrap  (row_wrap)
   );

   // Row-wrap columns (col_cnt < K-1) shift the chain but never emit a window.
   assign qualify  = accept & (row_cnt >= ROW_W'(KERNEL - 1)) & (col_cnt >= COL_W'(KERNEL - 1));
   assign last_win = win_valid & win_ready
                   & (win_row == ROW_W'(IMG_ROWS - KERNEL))
                   & (win_col == COL_W'(IMG_COLS - KERNEL));
   assign state_dbg = state_q;

   always_comb begin
      state_d    = state_q;
      in_ready   = 1'b0;
      start_acc  = 1'b0;
      busy       = 1'b0;
      frame_done = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               start_acc = 1'b1;
               state_d   = FILL;
            end
         end
         FILL: begin
            busy     = 1'b1;
            in_ready = ~in_done_q & (~win_valid | win_ready);
            if (in_valid & in_ready & (row_cnt == ROW_W'(KERNEL - 1))
                & (col_cnt == COL_W'(KERNEL - 1))) begin
               state_d = RUN;
            end
         end
         RUN: begin
            busy     = 1'b1;
            in_ready = ~in_done_q & (~win_valid | win_ready);
            if (last_win) state_d = DONE;
         end
         DONE: begin
            frame_done = 1'b1;
            state_d    = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign accept = in_valid & in_ready;
   assign buf_en = accept;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Input closes after the final raster pixel so the chain stops shifting.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         in_done_q <= 1'b0;
      end else if (start_acc) begin
         in_done_q <= 1'b0;
      end else if (accept & col_wrap & row_wrap) begin
         in_done_q <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         win_valid <= 1'b0;
         win_row   <= '0;
         win_col   <= '0;
      end else if (qualify) begin
         win_valid <= 1'b1;
         win_row   <= row_cnt - ROW_W'(KERNEL - 1);
         win_col   <= col_cnt - COL_W'(KERNEL - 1);
      end else if (win_ready) begin
         win_valid <= 1'b0;
      end
   end

`ifdef CONV_WIN_PERF_CNT_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         win_count <= '0;
      end else if (start_acc) begin
         win_count <= '0;
      end else if (win_valid & win_ready) begin
         win_count <= win_count + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_conv_window_ctrl.sv
// Bench for conv_window_ctrl: cycle model of the raster/window rules plus directed pins.
module tb_conv_window_ctrl;
   import conv_pkg::*;

   localparam int C     = 32;
   localparam int R     = 32;
   localparam int K     = 5;
   localparam int TOTAL = (R - K + 1) * (C - K + 1);

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic        in_valid = 1'b0;
   logic        win_ready = 1'b0;
   logic        in_ready, buf_en, win_valid, busy, frame_done;
   logic [4:0]  win_row, win_col;
   logic [10:0] win_count;
   conv_state_e state_dbg;

   conv_window_ctrl #(.IMG_COLS(C), .IMG_ROWS(R), .KERNEL(K)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .buf_en     (buf_en),
      .win_valid  (win_valid),
      .win_ready  (win_ready),
      .win_row    (win_row),
      .win_col    (win_col),
      .busy       (busy),
      .frame_done (frame_done),
`ifdef CONV_WIN_PERF_CNT_EN
      .win_count  (win_count),
`endif
      .state_dbg  (state_dbg)
   );

`ifndef CONV_WIN_PERF_CNT_EN
   assign win_count = '0;
`endif

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endfunction

   // Behavioural model: phase 0 idle, 1 active, 2 done; pix = pixels accepted.
   int phase = 0, pix = 0, wins = 0, m_wr = 0, m_wc = 0;
   bit m_wv = 0;
   logic [15:0] exp_q[$];
   int n_wv = 0, n_acc = 0, first_acc = -1;

   always @(negedge clk) begin
      bit e_inr, hs, acc;
      int r, c;
      logic [15:0] e;
      if (!rst) begin
         check("rst_in_ready", in_ready, 0);
         check("rst_win_valid", win_valid, 0);
         check("rst_busy", busy, 0);
         check("rst_frame_done", frame_done, 0);
         phase = 0; m_wv = 0; exp_q.delete();
      end else begin
         e_inr = (phase == 1) && (pix < R * C) && (!m_wv || win_ready);
         check("in_ready", in_ready, e_inr);
         check("buf_en", buf_en, e_inr && in_valid);
         check("win_valid", win_valid, m_wv);
         check("busy", busy, phase == 1);
         check("frame_done", frame_done, phase == 2);
         if (m_wv) check("win_pos", {win_row, win_col}, m_wr * 32 + m_wc);
         if (win_valid) begin
            n_wv++;
            if (first_acc < 0) first_acc = n_acc;
         end
         if (buf_en) n_acc++;
         hs  = m_wv && win_ready;
         acc = e_inr && in_valid;
         if (hs) begin
            if (exp_q.size() == 0) check("extra_window", 1, 0);
            else begin
               e = exp_q.pop_front();
               check("win_order", {win_row, win_col}, e);
            end
            wins++;
         end
         r = pix / C;
         c = pix % C;
         if (acc && r >= K - 1 && c >= K - 1) begin
            m_wv = 1; m_wr = r - (K - 1); m_wc = c - (K - 1);
         end else if (win_ready) m_wv = 0;
         if (acc) pix++;
         if (phase == 2) phase = 0;
         else if (phase == 0 && start) begin
            phase = 1; pix = 0; wins = 0; m_wv = 0;
            exp_q.delete();
            for (int i = 0; i <= R - K; i++)
               for (int j = 0; j <= C - K; j++) exp_q.push_back(16'(i * 32 + j));
         end else if (phase == 1 && hs && wins == TOTAL) phase = 2;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      n_wv = 0; n_acc = 0; first_acc = -1;
      start = 1'b1;
      tick();
      start = 1'b0;
      check("state_after_start", state_dbg, FILL);
      check("win_count_cleared", win_count, 0);
   endtask

   // Runs to frame_done; rnd selects random valid/ready, else full throughput.
   task automatic run_frame(input bit rnd, input int budget);
      bit done = 0;
      for (int i = 0; i < budget && !done; i++) begin
         in_valid  = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
         win_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
         start     = (i == 500) || ($urandom_range(0, 99) == 0);
         tick();
         if (frame_done) begin
            done = 1;
`ifdef CONV_WIN_PERF_CNT_EN
            check("win_count_final", win_count, TOTAL);
`endif
            start = 1'b1;
            tick();
            start = 1'b0;
            check("idle_after_done", state_dbg, IDLE);
         end
      end
      start = 1'b0;
      if (!done) check("frame_timeout", 0, 1);
   endtask

   initial begin
      bit found;
      repeat (3) tick();
      check("reset_state", state_dbg, IDLE);
      rst = 1'b1;
      in_valid = 1'b1;
      repeat (3) tick();
      check("idle_in_ready", in_ready, 0);
      check("model_total", TOTAL, 784);

      // Full throughput frame.
      pulse_start();
      run_frame(0, 3000);
      check("wv_cycles", n_wv, 784);
      check("first_win_acc", first_acc, 133);

      // Back-pressure at window (3,7).
      in_valid = 1'b1; win_ready = 1'b1;
      pulse_start();
      found = 0;
      for (int i = 0; i < 2000 && !found; i++) begin
         if (win_valid && win_row == 3 && win_col == 7) found = 1;
         else tick();
      end
      check("bp_found", found, 1);
      win_ready = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         check("bp_row", win_row, 3);
         check("bp_col", win_col, 7);
         check("bp_in_ready", in_ready, 0);
         check("bp_buf_en", buf_en, 0);
      end
      win_ready = 1'b1;
      tick();
      check("bp_resume_valid", win_valid, 1);
      check("bp_resume_pos", {win_row, win_col}, 3 * 32 + 8);
      run_frame(1, 20000);

      // Reset mid-RUN.
      pulse_start();
      found = 0;
      for (int i = 0; i < 20000 && !found; i++) begin
         in_valid  = $urandom_range(0, 3) != 0;
         win_ready = $urandom_range(0, 3) != 0;
         tick();
         if (state_dbg == RUN && win_valid && win_row >= 2) found = 1;
      end
      check("run_reached", found, 1);
      #2 rst = 1'b0;
      #1;
      check("async_win_valid", win_valid, 0);
      check("async_in_ready", in_ready, 0);
      check("async_busy", busy, 0);
      tick();
      rst = 1'b1;
      tick();
      check("post_reset_state", state_dbg, IDLE);

      // Random frame after reset re-primes the chain.
      pulse_start();
      run_frame(1, 20000);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
